decode_stage: RTL and testbench

Registered, parametrised successor to the combinational decoder. It accepts instructions from fetch over a valid/ready handshake and decodes the same opcode map into a one-entry pipeline register feeding execute. It adds three things the combinational decoder lacks: sign-extended immediates, illegal-instruction flagging, and load-use interlock (a one-cycle bubble). It also supports flush on branch redirect and keeps a stall performance counter.

---
 rtl/isa_pkg.sv | 74 +++++++
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_logic.sv | 74 +++++++
 rtl/decode_stage.sv | 143 ++++++++++++++
 tb/tb_decode_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// ISA definitions shared by the decode pipeline: opcode map, CTRL sub-ops,
// ALU operation encodings and instruction field extractors.
package isa_pkg;

    // Widest instruction word the field helpers can handle
    localparam int MAX_XLEN = 64;

    // Primary opcodes (top 6 bits of the instruction)
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_XOR   = 6'd4;
    localparam logic [5:0] OP_NOT   = 6'd5;
    localparam logic [5:0] OP_SHL   = 6'd6;
    localparam logic [5:0] OP_SHR   = 6'd7;
    localparam logic [5:0] OP_EQ    = 6'd8;
    localparam logic [5:0] OP_LT    = 6'd9;
    localparam logic [5:0] OP_GT    = 6'd10;
    localparam logic [5:0] OP_LOAD  = 6'd11;
    localparam logic [5:0] OP_STORE = 6'd12;
    localparam logic [5:0] OP_CTRL  = 6'd13;

    // CTRL sub-operations, carried in the rd field
    localparam int unsigned CTRL_JMP = 0;
    localparam int unsigned CTRL_BEQ = 1;
    localparam int unsigned CTRL_BLT = 2;
    localparam int unsigned CTRL_BGT = 3;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_EQ  = 4'd8;
    localparam logic [3:0] ALU_LT  = 4'd9;
    localparam logic [3:0] ALU_GT  = 4'd10;

    // Field extractors: the instruction is passed zero-extended to MAX_XLEN,
    // the result is right-aligned and the caller casts it to the field width.
    function automatic logic [MAX_XLEN-1:0] field_mask(input int width);
        return (MAX_XLEN'(1) << width) - MAX_XLEN'(1);
    endfunction

    function automatic logic [MAX_XLEN-1:0] field_opc(input logic [MAX_XLEN-1:0] inst,
                                                      input int xlen);
        return (inst >> (xlen - 6)) & field_mask(6);
    endfunction

    function automatic logic [MAX_XLEN-1:0] field_ra(input logic [MAX_XLEN-1:0] inst,
                                                     input int xlen, input int rw);
        return (inst >> (xlen - 6 - rw)) & field_mask(rw);
    endfunction

    function automatic logic [MAX_XLEN-1:0] field_rb(input logic [MAX_XLEN-1:0] inst,
                                                     input int xlen, input int rw);
        return (inst >> (xlen - 6 - 2*rw)) & field_mask(rw);
    endfunction

    function automatic logic [MAX_XLEN-1:0] field_rd(input logic [MAX_XLEN-1:0] inst,
                                                     input int xlen, input int rw);
        return (inst >> (xlen - 6 - 3*rw)) & field_mask(rw);
    endfunction

    function automatic logic [MAX_XLEN-1:0] field_imm(input logic [MAX_XLEN-1:0] inst,
                                                      input int xlen, input int rw);
        return inst & field_mask(xlen - 6 - 3*rw);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the fetch-side and execute-side handshake/payload signals of the
// decode stage. The master is the surrounding pipeline, the slave is decode.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RW   = 5
);
    logic            F_valid;
    logic            F_ready;
    logic [XLEN-1:0] F_inst;
    logic [XLEN-1:0] F_pc;
    logic            flush;

    logic            E_valid;
    logic            E_ready;
    logic [XLEN-1:0] E_pc;
    logic [5:0]      E_opc;
    logic [RW-1:0]   E_ra;
    logic [RW-1:0]   E_rb;
    logic [RW-1:0]   E_rd;
    logic [XLEN-1:0] E_imm;
    logic            E_we;
    logic [3:0]      E_alu_op;
    logic            E_ld;
    logic            E_str;
    logic            E_brn;
    logic            E_ill;

    modport master (
        output F_valid, F_inst, F_pc, flush, E_ready,
        input  F_ready, E_valid, E_pc, E_opc, E_ra, E_rb, E_rd, E_imm,
               E_we, E_alu_op, E_ld, E_str, E_brn, E_ill
    );

    modport slave (
        input  F_valid, F_inst, F_pc, flush, E_ready,
        output F_ready, E_valid, E_pc, E_opc, E_ra, E_rb, E_rd, E_imm,
               E_we, E_alu_op, E_ld, E_str, E_brn, E_ill
    );
endinterface

// File: rtl/decode_logic.sv
// Purely combinational instruction decoder: slices the fields, sign-extends
// the immediate and derives the control flags, ALU op, illegal flag and
// whether the instruction reads its rb operand.
module decode_logic
    import isa_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic [XLEN-1:0] inst_i,
    output logic [5:0]      opc_o,
    output logic [RW-1:0]   ra_o,
    output logic [RW-1:0]   rb_o,
    output logic [RW-1:0]   rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic            we_o,
    output logic [3:0]      alu_op_o,
    output logic            ld_o,
    output logic            str_o,
    output logic            brn_o,
    output logic            ill_o,
    output logic            uses_rb_o
);
    localparam int IMW = XLEN - 6 - 3*RW;

    logic [MAX_XLEN-1:0] inst_w;
    logic [IMW-1:0]      imm_raw;
    logic                is_ctrl;
    logic                ctrl_ok;

    assign inst_w  = MAX_XLEN'(inst_i);
    assign opc_o   = 6'(field_opc(inst_w, XLEN));
    assign ra_o    = RW'(field_ra(inst_w, XLEN, RW));
    assign rb_o    = RW'(field_rb(inst_w, XLEN, RW));
    assign rd_o    = RW'(field_rd(inst_w, XLEN, RW));
    assign imm_raw = IMW'(field_imm(inst_w, XLEN, RW));
    assign imm_o   = {{(XLEN-IMW){imm_raw[IMW-1]}}, imm_raw};

    assign is_ctrl = (opc_o == OP_CTRL);
    assign ctrl_ok = is_ctrl && (rd_o <= RW'(CTRL_BGT));
    assign ill_o   = (opc_o > OP_CTRL) || (is_ctrl && !ctrl_ok);

    // Control flags and ALU op; illegal encodings fall through to all-zero
    always_comb begin
        we_o      = 1'b0;
        alu_op_o  = ALU_ADD;
        ld_o      = 1'b0;
        str_o     = 1'b0;
        brn_o     = 1'b0;
        uses_rb_o = 1'b0;
        if (opc_o <= OP_GT) begin
            we_o      = 1'b1;
            alu_op_o  = opc_o[3:0];
            uses_rb_o = (opc_o != OP_NOT);
        end else if (opc_o == OP_LOAD) begin
            we_o = 1'b1;
            ld_o = 1'b1;
        end else if (opc_o == OP_STORE) begin
            str_o     = 1'b1;
            uses_rb_o = 1'b1;
        end else if (ctrl_ok) begin
            brn_o     = 1'b1;
            uses_rb_o = (rd_o != RW'(CTRL_JMP));
            if (rd_o == RW'(CTRL_BEQ)) begin
                alu_op_o = ALU_EQ;
            end else if (rd_o == RW'(CTRL_BLT)) begin
                alu_op_o = ALU_LT;
            end else if (rd_o == RW'(CTRL_BGT)) begin
                alu_op_o = ALU_GT;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes the fetch-side instruction into a one-entry
// output register, with valid/ready handshakes on both sides, a one-bubble
// load-use interlock, flush on redirect and a stall counter.
module decode_stage
    import isa_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int IMW = XLEN - 6 - 3*RW;

    if (IMW < 1 || XLEN > MAX_XLEN) begin : g_bad_params
        $error("decode_stage: immediate width must be >= 1 and XLEN <= 64");
    end

    logic [5:0]      dec_opc;
    logic [RW-1:0]   dec_ra, dec_rb, dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            dec_we, dec_ld, dec_str, dec_brn, dec_ill, dec_uses_rb;
    logic [3:0]      dec_alu_op;

    logic             out_valid_q, out_valid_d;
    logic             ld_pend_q, ld_pend_d;
    logic [RW-1:0]    ld_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [XLEN-1:0] pc_q, imm_q;
    logic [5:0]      opc_q;
    logic [RW-1:0]   ra_q, rb_q, rd_q;
    logic            we_q, ld_q, str_q, brn_q, ill_q, uses_rb_q;
    logic [3:0]      alu_op_q;

    logic hazard, e_valid, fire, f_ready, capture;

    decode_logic #(
        .XLEN (XLEN),
        .RW   (RW)
    ) u_decode_logic (
        .inst_i    (bus.F_inst),
        .opc_o     (dec_opc),
        .ra_o      (dec_ra),
        .rb_o      (dec_rb),
        .rd_o      (dec_rd),
        .imm_o     (dec_imm),
        .we_o      (dec_we),
        .alu_op_o  (dec_alu_op),
        .ld_o      (dec_ld),
        .str_o     (dec_str),
        .brn_o     (dec_brn),
        .ill_o     (dec_ill),
        .uses_rb_o (dec_uses_rb)
    );

    assign hazard  = out_valid_q & ld_pend_q &
                     ((ra_q == ld_rd_q) | (uses_rb_q & (rb_q == ld_rd_q)));
    assign e_valid = out_valid_q & ~hazard;
    assign fire    = e_valid & bus.E_ready;
    assign f_ready = ~out_valid_q | fire;
    assign capture = bus.F_valid & f_ready & ~bus.flush;

    // Next-state for occupancy, pending-load tracking and the stall counter
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (fire) begin
            out_valid_d = 1'b0;
        end
        ld_pend_d   = bus.flush ? 1'b0 : (fire & ld_q);
        stall_cnt_d = stall_cnt_q;
        if (hazard) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register: control state every cycle, payload only on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ld_pend_q   <= 1'b0;
            ld_rd_q     <= '0;
            stall_cnt_q <= '0;
            pc_q        <= '0;
            opc_q       <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            we_q        <= 1'b0;
            alu_op_q    <= '0;
            ld_q        <= 1'b0;
            str_q       <= 1'b0;
            brn_q       <= 1'b0;
            ill_q       <= 1'b0;
            uses_rb_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ld_pend_q   <= ld_pend_d;
            ld_rd_q     <= rd_q;
            stall_cnt_q <= stall_cnt_d;
            if (capture) begin
                pc_q      <= bus.F_pc;
                opc_q     <= dec_opc;
                ra_q      <= dec_ra;
                rb_q      <= dec_rb;
                rd_q      <= dec_rd;
                imm_q     <= dec_imm;
                we_q      <= dec_we;
                alu_op_q  <= dec_alu_op;
                ld_q      <= dec_ld;
                str_q     <= dec_str;
                brn_q     <= dec_brn;
                ill_q     <= dec_ill;
                uses_rb_q <= dec_uses_rb;
            end
        end
    end

    assign bus.F_ready  = f_ready;
    assign bus.E_valid  = e_valid;
    assign bus.E_pc     = pc_q;
    assign bus.E_opc    = opc_q;
    assign bus.E_ra     = ra_q;
    assign bus.E_rb     = rb_q;
    assign bus.E_rd     = rd_q;
    assign bus.E_imm    = imm_q;
    assign bus.E_we     = we_q;
    assign bus.E_alu_op = alu_op_q;
    assign bus.E_ld     = ld_q;
    assign bus.E_str    = str_q;
    assign bus.E_brn    = brn_q;
    assign bus.E_ill    = ill_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int CNT_W = 16;

    localparam logic [31:0] I_ADD   = 32'h00221800;
    localparam logic [31:0] I_LOAD  = 32'h2C202804;
    localparam logic [31:0] I_ADD2  = 32'h00A03000;
    localparam logic [31:0] I_IMMN  = 32'h000007FF;
    localparam logic [31:0] I_IMMP  = 32'h000003FF;
    localparam logic [31:0] I_OP63  = 32'hFC000000;
    localparam logic [31:0] I_CTRL5 = 32'h34002800;
    localparam logic [31:0] I_SUB   = 32'h04222000;
    localparam logic [31:0] I_AND   = 32'h08222800;
    localparam logic [31:0] I_OR    = 32'h0C223000;
    localparam logic [31:0] I_BEQ   = 32'h34220800;

    logic             clk = 1'b0;
    logic             rstN;
    logic [CNT_W-1:0] stallCnt;
    int               checkCount = 0;
    int               errorCount = 0;

    decode_stage_if #(.XLEN(XLEN), .RW(RW)) bus ();

    decode_stage #(
        .XLEN  (XLEN),
        .RW    (RW),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .bus       (bus),
        .stall_cnt (stallCnt)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after a rising edge, then wait for the falling edge
    task automatic applyStimulus(input logic fValid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic eReady,
                                 input logic fl);
        @(posedge clk);
        #1;
        bus.F_valid = fValid;
        bus.F_inst  = inst;
        bus.F_pc    = pc;
        bus.E_ready = eReady;
        bus.flush   = fl;
        @(negedge clk);
    endtask

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        rstN        = 1'b0;
        bus.F_valid = 1'b0;
        bus.F_inst  = '0;
        bus.F_pc    = '0;
        bus.E_ready = 1'b0;
        bus.flush   = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_E_valid", 32'(bus.E_valid), 32'd0);
        checkOutput("rst_F_ready", 32'(bus.F_ready), 32'd1);
        checkOutput("rst_stall", 32'(stallCnt), 32'd0);
        checkOutput("rst_E_pc", bus.E_pc, 32'd0);
        checkOutput("rst_E_imm", bus.E_imm, 32'd0);
        rstN = 1'b1;

        $display("[TB] single ADD");
        applyStimulus(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
        checkOutput("add_pre_valid", 32'(bus.E_valid), 32'd0);
        checkOutput("add_pre_ready", 32'(bus.F_ready), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("add_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("add_opc", 32'(bus.E_opc), 32'd0);
        checkOutput("add_alu", 32'(bus.E_alu_op), 32'd0);
        checkOutput("add_we", 32'(bus.E_we), 32'd1);
        checkOutput("add_ra", 32'(bus.E_ra), 32'd1);
        checkOutput("add_rb", 32'(bus.E_rb), 32'd2);
        checkOutput("add_rd", 32'(bus.E_rd), 32'd3);
        checkOutput("add_pc", bus.E_pc, 32'h100);
        checkOutput("add_F_ready", 32'(bus.F_ready), 32'd1);

        $display("[TB] load-use interlock");
        applyStimulus(1'b1, I_LOAD, 32'h104, 1'b1, 1'b0);
        checkOutput("lu_empty", 32'(bus.E_valid), 32'd0);
        applyStimulus(1'b1, I_ADD2, 32'h108, 1'b1, 1'b0);
        checkOutput("lu_ld_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("lu_ld_flag", 32'(bus.E_ld), 32'd1);
        checkOutput("lu_ld_rd", 32'(bus.E_rd), 32'd5);
        checkOutput("lu_ld_imm", bus.E_imm, 32'd4);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("lu_bubble", 32'(bus.E_valid), 32'd0);
        checkOutput("lu_bubble_ready", 32'(bus.F_ready), 32'd0);
        checkOutput("lu_bubble_cnt", 32'(stallCnt), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("lu_add_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("lu_add_pc", bus.E_pc, 32'h108);
        checkOutput("lu_add_ra", 32'(bus.E_ra), 32'd5);
        checkOutput("lu_add_rd", 32'(bus.E_rd), 32'd6);
        checkOutput("lu_cnt", 32'(stallCnt), 32'd1);

        $display("[TB] immediate sign extension");
        applyStimulus(1'b1, I_IMMN, 32'h10C, 1'b1, 1'b0);
        applyStimulus(1'b1, I_IMMP, 32'h110, 1'b1, 1'b0);
        checkOutput("imm_neg_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("imm_neg", bus.E_imm, 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("imm_pos", bus.E_imm, 32'h000003FF);

        $display("[TB] illegal encodings");
        applyStimulus(1'b1, I_OP63, 32'h114, 1'b1, 1'b0);
        applyStimulus(1'b1, I_CTRL5, 32'h118, 1'b1, 1'b0);
        checkOutput("ill63_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("ill63_ill", 32'(bus.E_ill), 32'd1);
        checkOutput("ill63_we", 32'(bus.E_we), 32'd0);
        checkOutput("ill63_ld", 32'(bus.E_ld), 32'd0);
        checkOutput("ill63_str", 32'(bus.E_str), 32'd0);
        checkOutput("ill63_brn", 32'(bus.E_brn), 32'd0);
        checkOutput("ill63_alu", 32'(bus.E_alu_op), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("illc_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("illc_ill", 32'(bus.E_ill), 32'd1);
        checkOutput("illc_we", 32'(bus.E_we), 32'd0);
        checkOutput("illc_brn", 32'(bus.E_brn), 32'd0);
        checkOutput("illc_alu", 32'(bus.E_alu_op), 32'd0);
        checkOutput("illc_rd", 32'(bus.E_rd), 32'd5);

        $display("[TB] backpressure");
        applyStimulus(1'b1, I_SUB, 32'h200, 1'b0, 1'b0);
        checkOutput("bp_empty", 32'(bus.E_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, I_AND, 32'h204, 1'b0, 1'b0);
            checkOutput("bp_hold_valid", 32'(bus.E_valid), 32'd1);
            checkOutput("bp_hold_ready", 32'(bus.F_ready), 32'd0);
            checkOutput("bp_hold_pc", bus.E_pc, 32'h200);
            checkOutput("bp_hold_opc", 32'(bus.E_opc), 32'd1);
            checkOutput("bp_hold_rd", 32'(bus.E_rd), 32'd4);
        end
        applyStimulus(1'b1, I_AND, 32'h204, 1'b1, 1'b0);
        checkOutput("bp_rel_pc", bus.E_pc, 32'h200);
        checkOutput("bp_rel_ready", 32'(bus.F_ready), 32'd1);
        applyStimulus(1'b1, I_OR, 32'h208, 1'b1, 1'b0);
        checkOutput("bp_i2_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("bp_i2_pc", bus.E_pc, 32'h204);
        checkOutput("bp_i2_alu", 32'(bus.E_alu_op), 32'd2);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_i3_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("bp_i3_pc", bus.E_pc, 32'h208);
        checkOutput("bp_i3_rd", 32'(bus.E_rd), 32'd6);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_drained", 32'(bus.E_valid), 32'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, I_BEQ, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, I_ADD, 32'h304, 1'b0, 1'b1);
        checkOutput("fl_beq_valid", 32'(bus.E_valid), 32'd1);
        checkOutput("fl_beq_brn", 32'(bus.E_brn), 32'd1);
        checkOutput("fl_beq_alu", 32'(bus.E_alu_op), 32'd8);
        checkOutput("fl_beq_pc", bus.E_pc, 32'h300);
        applyStimulus(1'b1, I_ADD, 32'h308, 1'b1, 1'b1);
        checkOutput("fl_killed", 32'(bus.E_valid), 32'd0);
        checkOutput("fl_empty_ready", 32'(bus.F_ready), 32'd1);
        checkOutput("fl_cnt", 32'(stallCnt), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("fl_dropped", 32'(bus.E_valid), 32'd0);
        checkOutput("fl_cnt_after", 32'(stallCnt), 32'd1);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, I_LOAD, 32'h400, 1'b1, 1'b0);
        applyStimulus(1'b1, I_ADD2, 32'h404, 1'b1, 1'b0);
        checkOutput("rs_ld", 32'(bus.E_ld), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("rs_bubble", 32'(bus.E_valid), 32'd0);
        checkOutput("rs_bubble_ready", 32'(bus.F_ready), 32'd0);
        checkOutput("rs_cnt_before", 32'(stallCnt), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rs_async_ready", 32'(bus.F_ready), 32'd1);
        checkOutput("rs_async_valid", 32'(bus.E_valid), 32'd0);
        checkOutput("rs_async_cnt", 32'(stallCnt), 32'd0);
        checkOutput("rs_async_pc", bus.E_pc, 32'd0);
        checkOutput("rs_async_ra", 32'(bus.E_ra), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rs_held_cnt", 32'(stallCnt), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("rs_after_valid", 32'(bus.E_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
